// File: rtl/rvfi_trace_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_trace_capture_if
// Description : RVFI retirement port plus the valid/ready trace record stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface rvfi_trace_capture_if;
    logic         rvfi_valid;
    logic [63:0]  rvfi_order;
    logic [31:0]  rvfi_insn;
    logic         rvfi_trap;
    logic         rvfi_halt;
    logic         rvfi_intr;
    logic [1:0]   rvfi_mode;
    logic [4:0]   rvfi_rd_addr;
    logic [31:0]  rvfi_rd_wdata;
    logic [31:0]  rvfi_pc_rdata;
    logic [31:0]  rvfi_mem_addr;
    logic [3:0]   rvfi_mem_rmask;
    logic [3:0]   rvfi_mem_wmask;
    logic         trace_valid_o;
    logic         trace_ready_i;
    logic [185:0] trace_data_o;

    modport master (
        output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt,
               rvfi_intr, rvfi_mode, rvfi_rd_addr, rvfi_rd_wdata,
               rvfi_pc_rdata, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
               trace_ready_i,
        input  trace_valid_o, trace_data_o
    );

    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt,
               rvfi_intr, rvfi_mode, rvfi_rd_addr, rvfi_rd_wdata,
               rvfi_pc_rdata, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
               trace_ready_i,
        output trace_valid_o, trace_data_o
    );
endinterface
`default_nettype wire

// File: rtl/rvfi_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_trace_capture
// Description : Packs RVFI retirements into 186-bit records, buffers them in a
//               FWFT FIFO and tracks retire/drop statistics and order gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_trace_capture #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  wire                       clk_i,
    input  wire                       rst_i,
    input  wire [31:0]                hart_id_i,
    input  wire                       clear_i,
    rvfi_trace_capture_if.slave       bus,
    output logic [CNT_W-1:0]          retire_cnt_o,
    output logic [CNT_W-1:0]          drop_cnt_o,
    output logic                      overflow_o,
    output logic                      order_err_o,
    output logic [$clog2(DEPTH):0]    fifo_level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] c_FULL = LW'(DEPTH);

    logic [185:0]      r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;
    logic [CNT_W-1:0]  r_retire_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic              r_overflow;
    logic              r_order_err;
    logic              r_base_set;
    logic [63:0]       r_base;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [31:0]       w_wdata_eff;
    logic [185:0]      w_record;
    logic [23:0]       w_unused_hart;

    assign w_unused_hart = hart_id_i[31:8];

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_FULL);
    assign w_pop   = !w_empty && bus.trace_ready_i;
    // A full FIFO still accepts a retirement when the head leaves on the same edge.
    assign w_push  = bus.rvfi_valid && (!w_full || w_pop);
    assign w_drop  = bus.rvfi_valid && w_full && !w_pop;

    assign w_wdata_eff = (bus.rvfi_rd_addr == 5'd0) ? 32'd0 : bus.rvfi_rd_wdata;
    assign w_record = {hart_id_i[7:0], bus.rvfi_order[31:0], bus.rvfi_pc_rdata,
                       bus.rvfi_insn, bus.rvfi_rd_addr, w_wdata_eff,
                       bus.rvfi_mem_addr, bus.rvfi_mem_rmask, bus.rvfi_mem_wmask,
                       bus.rvfi_trap, bus.rvfi_intr, bus.rvfi_halt, bus.rvfi_mode};

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_record;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Clear wins over same-cycle statistic updates; the FIFO itself is untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_retire_cnt <= '0;
            r_drop_cnt   <= '0;
            r_overflow   <= 1'b0;
            r_order_err  <= 1'b0;
            r_base_set   <= 1'b0;
            r_base       <= '0;
        end else if (clear_i) begin
            r_retire_cnt <= '0;
            r_drop_cnt   <= '0;
            r_overflow   <= 1'b0;
            r_order_err  <= 1'b0;
            r_base_set   <= 1'b0;
        end else if (bus.rvfi_valid) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
            if (r_base_set && (bus.rvfi_order != r_base + 64'd1)) begin
                r_order_err <= 1'b1;
            end
            r_base     <= bus.rvfi_order;
            r_base_set <= 1'b1;
        end
    end

    assign bus.trace_valid_o = !w_empty;
    assign bus.trace_data_o  = w_empty ? '0 : r_mem[r_rptr];
    assign retire_cnt_o      = r_retire_cnt;
    assign drop_cnt_o        = r_drop_cnt;
    assign overflow_o        = r_overflow;
    assign order_err_o       = r_order_err;
    assign fifo_level_o      = r_level;
endmodule
`default_nettype wire

// File: tb/tb_rvfi_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvfi_trace_capture
// Description : Randomized and directed bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfi_trace_capture;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [31:0]      hart_id_i;
    logic             clear_i;
    logic [CNT_W-1:0] retire_cnt_o;
    logic [CNT_W-1:0] drop_cnt_o;
    logic             overflow_o;
    logic             order_err_o;
    logic [$clog2(DEPTH):0] fifo_level_o;

    rvfi_trace_capture_if bus ();

    rvfi_trace_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .hart_id_i    (hart_id_i),
        .clear_i      (clear_i),
        .bus          (bus.slave),
        .retire_cnt_o (retire_cnt_o),
        .drop_cnt_o   (drop_cnt_o),
        .overflow_o   (overflow_o),
        .order_err_o  (order_err_o),
        .fifo_level_o (fifo_level_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [185:0]     m_q[$];
    logic [CNT_W-1:0] m_retire;
    logic [CNT_W-1:0] m_drop;
    logic             m_ovf;
    logic             m_err;
    logic             m_base_set;
    logic [63:0]      m_base;

    function automatic logic [185:0] make_rec();
        logic [31:0] wd;
        wd = (bus.rvfi_rd_addr == 5'd0) ? 32'd0 : bus.rvfi_rd_wdata;
        return {hart_id_i[7:0], bus.rvfi_order[31:0], bus.rvfi_pc_rdata,
                bus.rvfi_insn, bus.rvfi_rd_addr, wd, bus.rvfi_mem_addr,
                bus.rvfi_mem_rmask, bus.rvfi_mem_wmask, bus.rvfi_trap,
                bus.rvfi_intr, bus.rvfi_halt, bus.rvfi_mode};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_retire = '0; m_drop = '0; m_ovf = 0; m_err = 0;
        m_base_set = 0; m_base = '0;
    endtask

    task automatic model_step();
        bit pop, full, push, drop;
        logic [185:0] rec;
        pop  = bus.trace_ready_i && (m_q.size() > 0);
        full = (m_q.size() == DEPTH);
        push = bus.rvfi_valid && (!full || pop);
        drop = bus.rvfi_valid && !push;
        rec  = make_rec();
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(rec);
        if (clear_i) begin
            m_retire = '0; m_drop = '0; m_ovf = 0; m_err = 0; m_base_set = 0;
        end else if (bus.rvfi_valid) begin
            m_retire = m_retire + 1;
            if (drop) begin
                m_ovf = 1;
                if (m_drop != {CNT_W{1'b1}}) m_drop = m_drop + 1;
            end
            if (m_base_set && bus.rvfi_order != m_base + 64'd1) m_err = 1;
            m_base = bus.rvfi_order;
            m_base_set = 1;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        bus.rvfi_valid = 0;
        clear_i = 0;
    endtask

    task automatic set_retire(input logic [63:0] ord);
        bus.rvfi_valid     = 1;
        bus.rvfi_order     = ord;
        bus.rvfi_insn      = $urandom;
        bus.rvfi_trap      = 1'($urandom);
        bus.rvfi_halt      = 1'($urandom);
        bus.rvfi_intr      = 1'($urandom);
        bus.rvfi_mode      = 2'($urandom);
        bus.rvfi_rd_addr   = 5'($urandom);
        bus.rvfi_rd_wdata  = $urandom;
        bus.rvfi_pc_rdata  = $urandom;
        bus.rvfi_mem_addr  = $urandom;
        bus.rvfi_mem_rmask = 4'($urandom);
        bus.rvfi_mem_wmask = 4'($urandom);
    endtask

    task automatic do_clear();
        idle_inputs();
        clear_i = 1;
        cycle();
        clear_i = 0;
    endtask

    task automatic drain();
        idle_inputs();
        bus.trace_ready_i = 1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
    endtask

    task automatic test_reset();
        rst_i = 1;
        idle_inputs();
        bus.trace_ready_i = 0;
        hart_id_i = 32'h0000_00A5;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 0;
        @(negedge clk_i);
        checks += 5;
        if (bus.trace_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.trace_valid_o); end
        if (fifo_level_o !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level_o); end
        if (bus.trace_data_o !== '0) begin errors++; $display("FAIL reset_data got %h want 0", bus.trace_data_o); end
        if (retire_cnt_o !== '0 || drop_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", retire_cnt_o, drop_cnt_o); end
        if (overflow_o !== 1'b0 || order_err_o !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", overflow_o, order_err_o); end
    endtask

    task automatic test_single();
        logic [185:0] exp;
        set_retire(64'd5);
        bus.rvfi_pc_rdata = 32'h0000_0080; bus.rvfi_insn = 32'h0010_0093;
        bus.rvfi_rd_addr = 5'd1; bus.rvfi_rd_wdata = 32'd1;
        bus.rvfi_mem_addr = 32'd0; bus.rvfi_mem_rmask = 4'd0; bus.rvfi_mem_wmask = 4'd0;
        bus.rvfi_trap = 0; bus.rvfi_intr = 0; bus.rvfi_halt = 0; bus.rvfi_mode = 2'd3;
        bus.trace_ready_i = 1;
        exp = {8'hA5, 32'd5, 32'h0000_0080, 32'h0010_0093, 5'd1, 32'd1,
               32'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd3};
        cycle();
        idle_inputs();
        checks += 3;
        if (bus.trace_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.trace_valid_o); end
        if (bus.trace_data_o !== exp) begin errors++; $display("FAIL single_data got %h want %h", bus.trace_data_o, exp); end
        if (retire_cnt_o !== 32'd1) begin errors++; $display("FAIL single_retire got %0d want 1", retire_cnt_o); end
        cycle();
        checks++;
        if (fifo_level_o !== '0) begin errors++; $display("FAIL single_level got %0d want 0", fifo_level_o); end
    endtask

    task automatic test_rd_zero();
        set_retire(64'd6);
        bus.rvfi_rd_addr = 5'd0; bus.rvfi_rd_wdata = 32'hDEAD_BEEF;
        bus.trace_ready_i = 0;
        cycle();
        idle_inputs();
        checks += 2;
        if (bus.trace_valid_o !== 1'b1) begin errors++; $display("FAIL rdzero_valid got %b want 1", bus.trace_valid_o); end
        if (bus.trace_data_o[76:45] !== 32'd0) begin errors++; $display("FAIL rdzero_wdata got %h want 0", bus.trace_data_o[76:45]); end
        drain();
    endtask

    task automatic test_overflow();
        do_clear();
        bus.trace_ready_i = 0;
        for (int i = 0; i < 6; i++) begin set_retire(64'(i)); cycle(); end
        idle_inputs();
        checks += 4;
        if (fifo_level_o !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", fifo_level_o); end
        if (drop_cnt_o !== 32'd2) begin errors++; $display("FAIL ovf_drop got %0d want 2", drop_cnt_o); end
        if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow_o); end
        if (retire_cnt_o !== 32'd6) begin errors++; $display("FAIL ovf_retire got %0d want 6", retire_cnt_o); end
        bus.trace_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.trace_valid_o !== 1'b1 || bus.trace_data_o[177:146] !== 32'(i)) begin
                errors++; $display("FAIL ovf_drain%0d got v=%b order=%0d want v=1 order=%0d",
                                   i, bus.trace_valid_o, bus.trace_data_o[177:146], i);
            end
            cycle();
        end
        checks++;
        if (bus.trace_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", bus.trace_valid_o); end
    endtask

    task automatic test_back_to_back();
        do_clear();
        bus.trace_ready_i = 0;
        for (int i = 0; i < 4; i++) begin set_retire(64'(20 + i)); cycle(); end
        set_retire(64'd24);
        bus.trace_ready_i = 1;
        cycle();
        idle_inputs();
        bus.trace_ready_i = 0;
        checks += 3;
        if (fifo_level_o !== 3'd4) begin errors++; $display("FAIL b2b_level got %0d want 4", fifo_level_o); end
        if (drop_cnt_o !== 32'd0) begin errors++; $display("FAIL b2b_drop got %0d want 0", drop_cnt_o); end
        if (bus.trace_data_o[177:146] !== 32'd21) begin errors++; $display("FAIL b2b_head got %0d want 21", bus.trace_data_o[177:146]); end
        drain();
    endtask

    task automatic test_order();
        do_clear();
        bus.trace_ready_i = 1;
        set_retire(64'd10); cycle();
        set_retire(64'd11); cycle();
        idle_inputs();
        checks++;
        if (order_err_o !== 1'b0) begin errors++; $display("FAIL order_seq got %b want 0", order_err_o); end
        set_retire(64'd13); cycle();
        idle_inputs();
        checks++;
        if (order_err_o !== 1'b1) begin errors++; $display("FAIL order_gap got %b want 1", order_err_o); end
        do_clear();
        checks++;
        if (order_err_o !== 1'b0 || overflow_o !== 1'b0 || retire_cnt_o !== '0 || drop_cnt_o !== '0) begin
            errors++; $display("FAIL order_clear got err=%b ovf=%b ret=%0d drop=%0d want all 0",
                               order_err_o, overflow_o, retire_cnt_o, drop_cnt_o);
        end
        set_retire(64'd100); cycle();
        set_retire(64'd101); cycle();
        idle_inputs();
        checks++;
        if (order_err_o !== 1'b0) begin errors++; $display("FAIL order_after_clear got %b want 0", order_err_o); end
        drain();
    endtask

    task automatic test_async_reset();
        bus.trace_ready_i = 0;
        for (int i = 0; i < 3; i++) begin set_retire(64'(102 + i)); cycle(); end
        idle_inputs();
        checks++;
        if (fifo_level_o !== 3'd3) begin errors++; $display("FAIL arst_pre got %0d want 3", fifo_level_o); end
        #1 rst_i = 1;
        #1;
        checks += 2;
        if (bus.trace_valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", bus.trace_valid_o); end
        if (fifo_level_o !== '0) begin errors++; $display("FAIL arst_level got %0d want 0", fifo_level_o); end
        model_reset();
        @(negedge clk_i);
        rst_i = 0;
    endtask

    task automatic test_random();
        logic [63:0] ord;
        ord = 64'($urandom) << 20;
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            if ($urandom_range(0, 99) < 60) begin
                ord = ($urandom_range(0, 19) == 0) ? ord + 64'($urandom_range(2, 9)) : ord + 64'd1;
                set_retire(ord);
            end
            clear_i = ($urandom_range(0, 49) == 0);
            bus.trace_ready_i = ($urandom_range(0, 99) < 45);
            hart_id_i = $urandom;
            cycle();
            checks += 7;
            if (bus.trace_valid_o !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid n=%0d got %b want %b", n, bus.trace_valid_o, m_q.size() > 0); end
            if (m_q.size() > 0 && bus.trace_data_o !== m_q[0]) begin errors++; $display("FAIL rnd_data n=%0d got %h want %h", n, bus.trace_data_o, m_q[0]); end
            if (fifo_level_o !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_level n=%0d got %0d want %0d", n, fifo_level_o, m_q.size()); end
            if (retire_cnt_o !== m_retire) begin errors++; $display("FAIL rnd_retire n=%0d got %0d want %0d", n, retire_cnt_o, m_retire); end
            if (drop_cnt_o !== m_drop) begin errors++; $display("FAIL rnd_drop n=%0d got %0d want %0d", n, drop_cnt_o, m_drop); end
            if (overflow_o !== m_ovf) begin errors++; $display("FAIL rnd_ovf n=%0d got %b want %b", n, overflow_o, m_ovf); end
            if (order_err_o !== m_err) begin errors++; $display("FAIL rnd_order n=%0d got %b want %b", n, order_err_o, m_err); end
        end
    endtask

    initial begin
        bus.rvfi_valid = 0; bus.rvfi_order = '0; bus.rvfi_insn = '0;
        bus.rvfi_trap = 0; bus.rvfi_halt = 0; bus.rvfi_intr = 0; bus.rvfi_mode = '0;
        bus.rvfi_rd_addr = '0; bus.rvfi_rd_wdata = '0; bus.rvfi_pc_rdata = '0;
        bus.rvfi_mem_addr = '0; bus.rvfi_mem_rmask = '0; bus.rvfi_mem_wmask = '0;
        bus.trace_ready_i = 0;
        test_reset();
        test_single();
        test_rd_zero();
        test_overflow();
        test_back_to_back();
        test_order();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rvfi_trace_capture.md
Name: rvfi_trace_capture

Overview:
- Synthesizable retirement-trace capture block for the Ibex core.
- Samples the core's RVFI retirement port and packs each retired instruction into a fixed-format trace record.
- Buffers records in a small first-word-fall-through FIFO with a valid/ready output stream, and maintains retirement statistics and order-integrity flags.
- Sits beside the core top level, in place of a simulation-only text tracer.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 32, width of the retire and drop counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- hart_id_i  in  32  hart identifier; bits [7:0] go into each record
- clear_i  in  1  synchronous clear of counters, sticky flags and the order baseline
- rvfi_valid  in  1  an instruction retires this cycle
- rvfi_order  in  64  retirement sequence number
- rvfi_insn  in  32  instruction word
- rvfi_trap  in  1  instruction trapped
- rvfi_halt  in  1  halt
- rvfi_intr  in  1  first instruction of a trap handler
- rvfi_mode  in  2  privilege mode
- rvfi_rd_addr  in  5  destination register
- rvfi_rd_wdata  in  32  destination write data
- rvfi_pc_rdata  in  32  PC of the retired instruction
- rvfi_mem_addr  in  32  memory address
- rvfi_mem_rmask  in  4  read byte mask
- rvfi_mem_wmask  in  4  write byte mask
- trace_valid_o  out  1  FIFO head is valid
- trace_ready_i  in  1  consumer accepts the head
- trace_data_o  out  186  record at the FIFO head
- retire_cnt_o  out  CNT_W  count of rvfi_valid cycles (wraps)
- drop_cnt_o  out  CNT_W  count of records lost to a full FIFO (saturates)
- overflow_o  out  1  sticky: at least one record dropped
- order_err_o  out  1  sticky: rvfi_order discontinuity
- fifo_level_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Record layout, MSB to LSB: hart_id[7:0], order[31:0], pc_rdata, insn, rd_addr, rd_wdata_eff, mem_addr, mem_rmask, mem_wmask, trap, intr, halt, mode. Total 186 bits.
- rd_wdata_eff is 0 when rvfi_rd_addr==0, otherwise rvfi_rd_wdata.
- Reset (rst_i high, asynchronous):
  - FIFO empty, so trace_valid_o=0 and fifo_level_o=0.
  - All counters and flags 0.
  - Order baseline cleared to "unset".
  - trace_data_o is don't-care while trace_valid_o=0; implement it as 0.
- Push: on a rising edge with rvfi_valid=1, the record is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - The record becomes visible at the head one cycle after the push edge when the FIFO was empty.
  - Latency is therefore 1 cycle from rvfi_valid to trace_valid_o.
- Pop: occurs when trace_valid_o && trace_ready_i at a clock edge. Data is first-word-fall-through: trace_data_o always shows the oldest entry.
- Drop: rvfi_valid=1, FIFO full and no pop in that cycle.
  - Record discarded.
  - drop_cnt_o increments, saturating at all-ones.
  - overflow_o set.
- Simultaneous push and pop on an empty FIFO cannot occur, because valid is low. Push and pop at the same edge otherwise leave the level unchanged.
- Pointers wrap modulo DEPTH. Full means level==DEPTH; empty means level==0.
- retire_cnt_o increments on every rvfi_valid cycle, whether the record is accepted or dropped, and wraps.
- Order check:
  - First rvfi_valid after reset or clear stores rvfi_order as the baseline; no check is made.
  - Each later rvfi_valid compares rvfi_order against baseline+1 at full 64-bit width. A mismatch sets order_err_o; the baseline is then updated to rvfi_order regardless of the result.
- clear_i has priority over same-cycle updates of counters and flags:
  - Clears retire_cnt_o, drop_cnt_o, overflow_o and order_err_o, and returns the baseline to unset.
  - A same-cycle rvfi_valid is still pushed, but is not counted and does not set the baseline.
  - Does not flush the FIFO.
- Reset asserted mid-stream flushes the FIFO immediately; any records in flight are lost.
- No combinational path from rvfi_* to any output. trace_valid_o is registered-derived.

Test Plan:
- Reset, then a single retire with order=5, pc=0x0000_0080, insn=0x0010_0093, rd=1, wdata=1, ready=1 -> trace_valid_o high 1 cycle later with the exact 186-bit record; retire_cnt_o=1; level returns to 0.
- Retire with rd_addr=0, rd_wdata=0xDEADBEEF -> record rd_wdata field = 0.
- ready=0 and 6 consecutive retires with DEPTH=4 -> level=4; drop_cnt_o=2; overflow_o=1; retire_cnt_o=6. Raising ready drains records for orders 0..3 in order.
- FIFO full, ready=1 and rvfi_valid=1 on the same edge -> push accepted; level stays 4; drop_cnt_o unchanged.
- Orders 10, 11, 13 -> order_err_o=1 after the third retire. Then clear_i -> all flags and counters 0. Orders 100, 101 after the clear -> no error.
- Assert rst_i asynchronously with 3 queued records -> trace_valid_o=0 and fifo_level_o=0 before the next clock edge.
